// File: rtl/clock_pkg.sv
// Shared types and defaults for the alarm controller.
package clock_pkg;

   // FSM state encoding, also shown on the state LEDs.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ARMED  = 2'd1,
      RING   = 2'd2,
      SNOOZE = 2'd3
   } alarm_state_t;

   localparam int RING_SEC_DEF   = 60;
   localparam int SNOOZE_SEC_DEF = 300;
   localparam int MAX_SNOOZE_DEF = 3;

   // Bits needed to hold 0..max_val; never less than one bit.
   function automatic int cnt_width(input int max_val);
      return ($clog2(max_val + 1) < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/alarm_ctrl_if.sv
// Signal bundle between the clock front panel / time base and the alarm controller.
interface alarm_ctrl_if;

   logic        tick_1hz;
   logic        tone_tick;
   logic [23:0] time_bcd;
   logic [23:0] alarm_bcd;
   logic        alarm_on;
   logic        setting;
   logic        stop;
   logic        snooze;
   logic        bee_out;
   logic        ringing;
   logic [1:0]  state;

   // Driver side: time base and buttons.
   modport master (
      output tick_1hz, tone_tick, time_bcd, alarm_bcd, alarm_on, setting, stop, snooze,
      input  bee_out, ringing, state
   );

   // Alarm controller side.
   modport slave (
      input  tick_1hz, tone_tick, time_bcd, alarm_bcd, alarm_on, setting, stop, snooze,
      output bee_out, ringing, state
   );

endinterface

// File: rtl/sec_downcounter.sv
// Loadable seconds down-counter that stops at zero; shared by ring and snooze timing.
module sec_downcounter #(
   parameter int W = 9
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic [W-1:0] cnt,
   output logic         zero
);

   logic [W-1:0] cnt_q;

   // Load has priority over decrement; decrement saturates at zero.
   // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= load_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign cnt  = cnt_q;
   assign zero = (cnt_q == '0);

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm controller: match detection, ring/snooze FSM and buzzer tone generation.
module alarm_ctrl
   import clock_pkg::*;
#(
   parameter int RING_SEC   = RING_SEC_DEF,
   parameter int SNOOZE_SEC = SNOOZE_SEC_DEF,
   parameter int MAX_SNOOZE = MAX_SNOOZE_DEF
) (
   input  logic         clk,
   input  logic         rst,
   alarm_ctrl_if.slave  bus
);

   localparam int CNT_W = cnt_width((RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC);
   localparam int SNZ_W = cnt_width(MAX_SNOOZE);

   alarm_state_t     state_q;
   logic             ringing_q;
   logic             beat_q;
   logic             tone_q;
   logic             match_q;
   logic [SNZ_W-1:0] snooze_cnt;

   logic             match;
   logic             hit;
   logic             snooze_ok;
   logic             timeout;
   logic             cnt_load;
   logic [CNT_W-1:0] cnt_val;
   logic             cnt_dec;
   logic [CNT_W-1:0] sec_cnt;
   logic             sec_zero;

   assign match     = (bus.time_bcd == bus.alarm_bcd);
   // Rising edge of the match only, so a time held at the alarm value rings once.
   assign hit       = match & ~match_q & ~bus.setting;
   assign snooze_ok = bus.snooze && (snooze_cnt < SNZ_W'(MAX_SNOOZE));
   // A counter already at zero also expires, so a zero-length interval cannot strand the FSM.
   assign timeout   = bus.tick_1hz & ((sec_cnt == CNT_W'(1)) | sec_zero);

   sec_downcounter #(.W(CNT_W)) u_sec_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .load_val (cnt_val),
      .dec      (cnt_dec),
      .cnt      (sec_cnt),
      .zero     (sec_zero)
   );

   // Counter control follows the same event priority as the FSM below.
   // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      cnt_load = 1'b0;
      cnt_val  = CNT_W'(RING_SEC);
      cnt_dec  = 1'b0;
      if (bus.alarm_on) begin
         case (state_q)
            ARMED:  cnt_load = hit;
            RING: begin
               if (!bus.stop) begin
                  if (snooze_ok) begin
                     cnt_load = 1'b1;
                     cnt_val  = CNT_W'(SNOOZE_SEC);
                  end else begin
                     cnt_dec = bus.tick_1hz;
                  end
               end
            end
            SNOOZE: begin
               if (!bus.stop) begin
                  if (timeout) cnt_load = 1'b1;
                  else         cnt_dec  = bus.tick_1hz;
               end
            end
            default: ;
         endcase
      end
   end

   // Alarm FSM with registered ringing flag, beat and snooze count.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         ringing_q  <= 1'b0;
         beat_q     <= 1'b0;
         snooze_cnt <= '0;
         // NOTE: reset to 1 so a time already equal to the alarm at release is not a fresh hit.
         match_q    <= 1'b1;
      end else begin
         match_q <= match;
         if (!bus.alarm_on) begin
            state_q   <= IDLE;
            ringing_q <= 1'b0;
         end else begin
            case (state_q)
               IDLE: begin
                  state_q   <= ARMED;
                  ringing_q <= 1'b0;
               end
               ARMED: begin
                  if (hit) begin
                     state_q    <= RING;
                     ringing_q  <= 1'b1;
                     beat_q     <= 1'b1;
                     snooze_cnt <= '0;
                  end
               end
               RING: begin
                  if (bus.stop) begin
                     state_q   <= ARMED;
                     ringing_q <= 1'b0;
                  end else if (snooze_ok) begin
                     state_q    <= SNOOZE;
                     ringing_q  <= 1'b0;
                     snooze_cnt <= snooze_cnt + 1'b1;
                  end else if (timeout) begin
                     state_q   <= ARMED;
                     ringing_q <= 1'b0;
                  end else if (bus.tick_1hz) begin
                     beat_q <= ~beat_q;
                  end
               end
               SNOOZE: begin
                  if (bus.stop) begin
                     state_q   <= ARMED;
                     ringing_q <= 1'b0;
                  end else if (timeout) begin
                     state_q   <= RING;
                     ringing_q <= 1'b1;
                     beat_q    <= 1'b1;
                  end
               end
               default: begin
                  state_q   <= IDLE;
                  ringing_q <= 1'b0;
               end
            endcase
         end
      end
   end

   // Tone square wave during the "on" half of each beat, held low otherwise.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tone_q <= 1'b0;
      end else if (ringing_q && beat_q) begin
         if (bus.tone_tick) tone_q <= ~tone_q;
      end else begin
         tone_q <= 1'b0;
      end
   end

   assign bus.bee_out = tone_q;
   assign bus.ringing = ringing_q;
   assign bus.state   = state_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed scoreboard bench for alarm_ctrl with default timing parameters.
module tb_alarm_ctrl;
   import clock_pkg::*;

   typedef struct {
      string      tag;
      logic [1:0] st;
      logic       rg;
      logic       bee;
      bit         chk_bee;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   total = 0;
   int   bad = 0;
   int   secs = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   alarm_ctrl_if aif ();

   alarm_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (aif)
   );

   function automatic logic [23:0] to_bcd(input int s);
      int h, m, x;
      h = s / 3600;
      m = (s / 60) % 60;
      x = s % 60;
      return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_time(input int s);
      secs = s;
      aif.time_bcd = to_bcd(s);
   endtask

   // One-second pulse; the time value changes on the same edge that samples the tick.
   task automatic sec_tick(input bit adv);
      aif.tick_1hz = 1'b1;
      cyc();
      aif.tick_1hz = 1'b0;
      if (adv) set_time(secs + 1);
   endtask

   task automatic ticks(input int n);
      aif.tick_1hz = 1'b1;
      repeat (n) cyc();
      aif.tick_1hz = 1'b0;
   endtask

   task automatic tone_pulse();
      aif.tone_tick = 1'b1;
      cyc();
      aif.tone_tick = 1'b0;
   endtask

   task automatic press(input bit s, input bit z);
      aif.stop   = s;
      aif.snooze = z;
      cyc();
      aif.stop   = 1'b0;
      aif.snooze = 1'b0;
   endtask

   task automatic expect_out(input string tag, input logic [1:0] st, input logic rg,
                             input logic bee, input bit chk_bee);
      exp_t e;
      e.tag = tag; e.st = st; e.rg = rg; e.bee = bee; e.chk_bee = chk_bee;
      sb.push_back(e);
   endtask

   task automatic drain();
      exp_t       e;
      logic [3:0] obs, exp;
      while (sb.size() > 0) begin
         e   = sb.pop_front();
         obs = {aif.state, aif.ringing, e.chk_bee ? aif.bee_out : 1'b0};
         exp = {e.st, e.rg, e.chk_bee ? e.bee : 1'b0};
         total++;
         assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got state=%0d ringing=%b bee_out=%b, want state=%0d ringing=%b bee_out=%b",
                   e.tag, aif.state, aif.ringing, aif.bee_out, e.st, e.rg, e.bee);
         end
      end
   endtask

   // Time 4 -> 5 produces a hit; ringing must appear one edge after the match.
   task automatic ring_up(input string tag);
      set_time(4);
      cyc();
      sec_tick(1'b1);
      expect_out({tag, "_match"}, ARMED, 1'b0, 1'b0, 1'b0);
      drain();
      cyc();
      expect_out({tag, "_ring"}, RING, 1'b1, 1'b0, 1'b1);
      drain();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      aif.tick_1hz  = 1'b0;
      aif.tone_tick = 1'b0;
      aif.alarm_bcd = to_bcd(5);
      aif.alarm_on  = 1'b1;
      aif.setting   = 1'b0;
      aif.stop      = 1'b0;
      aif.snooze    = 1'b0;
      set_time(0);

      // Reset state and arming.
      #12;
      expect_out("reset", IDLE, 1'b0, 1'b0, 1'b1);
      drain();
      @(negedge clk);
      rst = 1'b1;
      cyc();
      expect_out("arm", ARMED, 1'b0, 1'b0, 1'b1);
      drain();

      // Count up to the alarm time.
      repeat (4) sec_tick(1'b1);
      expect_out("count_4s", ARMED, 1'b0, 1'b0, 1'b1);
      drain();
      sec_tick(1'b1);
      expect_out("match_edge", ARMED, 1'b0, 1'b0, 1'b1);
      drain();
      cyc();
      expect_out("ring_latency", RING, 1'b1, 1'b0, 1'b1);
      drain();

      // Tone toggles on tone_tick while the beat is on.
      tone_pulse();
      expect_out("tone_1", RING, 1'b1, 1'b1, 1'b1);
      drain();
      tone_pulse();
      expect_out("tone_2", RING, 1'b1, 1'b0, 1'b1);
      drain();
      tone_pulse();
      expect_out("tone_3", RING, 1'b1, 1'b1, 1'b1);
      drain();

      // Beat: 1 s off then 1 s on; time is held at the alarm value from here on.
      sec_tick(1'b0);
      cyc();
      expect_out("beat_off", RING, 1'b1, 1'b0, 1'b1);
      drain();
      tone_pulse();
      expect_out("beat_off_tone", RING, 1'b1, 1'b0, 1'b1);
      drain();
      sec_tick(1'b0);
      tone_pulse();
      expect_out("beat_on_tone", RING, 1'b1, 1'b1, 1'b1);
      drain();

      // Timeout after 60 ticks in RING (2 already spent).
      ticks(57);
      expect_out("ring_59_ticks", RING, 1'b1, 1'b0, 1'b0);
      drain();
      ticks(1);
      expect_out("ring_timeout", ARMED, 1'b0, 1'b0, 1'b0);
      drain();
      cyc();
      expect_out("timeout_quiet", ARMED, 1'b0, 1'b0, 1'b1);
      drain();
      repeat (20) cyc();
      expect_out("held_no_rering", ARMED, 1'b0, 1'b0, 1'b1);
      drain();

      // Three snoozes accepted, fourth ignored.
      ring_up("snz");
      for (int i = 0; i < 3; i++) begin
         press(1'b0, 1'b1);
         expect_out($sformatf("snz%0d_enter", i), SNOOZE, 1'b0, 1'b0, 1'b0);
         drain();
         ticks(299);
         expect_out($sformatf("snz%0d_299", i), SNOOZE, 1'b0, 1'b0, 1'b1);
         drain();
         ticks(1);
         expect_out($sformatf("snz%0d_rering", i), RING, 1'b1, 1'b0, 1'b1);
         drain();
      end
      press(1'b0, 1'b1);
      expect_out("snz4_ignored", RING, 1'b1, 1'b0, 1'b0);
      drain();
      repeat (3) cyc();
      expect_out("snz4_still_ring", RING, 1'b1, 1'b0, 1'b0);
      drain();

      // Stop and snooze together: stop wins.
      press(1'b1, 1'b1);
      expect_out("stop_snz_at_max", ARMED, 1'b0, 1'b0, 1'b0);
      drain();
      ring_up("ss");
      press(1'b1, 1'b1);
      expect_out("stop_beats_snooze", ARMED, 1'b0, 1'b0, 1'b0);
      drain();
      ring_up("fresh");
      press(1'b0, 1'b1);
      expect_out("snz_cnt_fresh", SNOOZE, 1'b0, 1'b0, 1'b0);
      drain();
      press(1'b1, 1'b0);
      expect_out("snooze_stop", ARMED, 1'b0, 1'b0, 1'b1);
      drain();
      press(1'b1, 1'b1);
      expect_out("armed_ignores_buttons", ARMED, 1'b0, 1'b0, 1'b1);
      drain();

      // setting=1 masks the match, and releasing it later is not a hit.
      set_time(4);
      aif.setting = 1'b1;
      cyc();
      sec_tick(1'b1);
      repeat (3) cyc();
      expect_out("setting_block", ARMED, 1'b0, 1'b0, 1'b1);
      drain();
      aif.setting = 1'b0;
      repeat (3) cyc();
      expect_out("setting_release", ARMED, 1'b0, 1'b0, 1'b1);
      drain();

      // alarm_on=0 during SNOOZE forces IDLE next edge.
      ring_up("off");
      press(1'b0, 1'b1);
      expect_out("off_snooze", SNOOZE, 1'b0, 1'b0, 1'b0);
      drain();
      aif.alarm_on = 1'b0;
      cyc();
      expect_out("off_to_idle", IDLE, 1'b0, 1'b0, 1'b1);
      drain();
      aif.alarm_on = 1'b1;
      cyc();
      expect_out("rearm", ARMED, 1'b0, 1'b0, 1'b1);
      drain();

      // Asynchronous reset mid-RING silences the buzzer without a clock edge.
      ring_up("rst");
      tone_pulse();
      expect_out("pre_reset_tone", RING, 1'b1, 1'b1, 1'b1);
      drain();
      #2;
      rst = 1'b0;
      #1;
      expect_out("async_reset", IDLE, 1'b0, 1'b0, 1'b1);
      drain();
      repeat (2) cyc();
      @(negedge clk);
      rst = 1'b1;
      cyc();
      expect_out("post_reset_arm", ARMED, 1'b0, 1'b0, 1'b1);
      drain();
      repeat (5) cyc();
      expect_out("post_reset_no_hit", ARMED, 1'b0, 1'b0, 1'b1);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
